// File: rtl/sprite_line_engine.sv
// Scanline sprite engine: fetches one row per Y-visible sprite during hblank
// and resolves the highest-priority opaque sprite pixel during active video.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   line_start,line_y start a fetch for signed line line_y
//   cfg_idx/cfg_data  sprite control word lookup (combinational return)
//   mem_req/addr/ack/data  variable-latency row fetch port
//   pix_valid,pix_x   pixel position query
//   px_valid/pixel/palette  registered winning pixel (1-cycle latency)
//   collision_mask    sticky per-sprite overlap flags
//   clr_collision     clears collision_mask and fetch_overrun
//   fetch_done        all sprites of the current line processed
//   fetch_overrun     sticky; pixel or new line arrived before fetch finished
module sprite_line_engine #(
    parameter int NUM_SPRITES = 8,
    parameter int SPRITE_W    = 16,
    parameter int BPP         = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_start,
    input  logic [8:0]                line_y,
    output logic [3:0]                cfg_idx,
    input  logic [31:0]               cfg_data,
    output logic                      mem_req,
    output logic [8:0]                mem_addr,
    input  logic                      mem_ack,
    input  logic [SPRITE_W*BPP-1:0]   mem_data,
    input  logic                      pix_valid,
    input  logic [9:0]                pix_x,
    output logic                      px_valid,
    output logic [BPP-1:0]            px_pixel,
    output logic [3:0]                px_palette,
    output logic [NUM_SPRITES-1:0]    collision_mask,
    input  logic                      clr_collision,
    output logic                      fetch_done,
    output logic                      fetch_overrun
);

    localparam int RW = SPRITE_W * BPP;

    typedef enum logic [1:0] {IDLE, CFG, REQ, DONE} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             s_q, s_d;
    logic [NUM_SPRITES-1:0] loaded_q;
    logic                   xflip_q;
    logic [8:0]             mem_addr_q;

    logic [RW-1:0]          row_buf [NUM_SPRITES];
    logic [9:0]             spr_x   [NUM_SPRITES];
    logic [3:0]             spr_pal [NUM_SPRITES];

    logic                   buf_we, cfg_we;
    logic                   set_loaded, clr_loaded, line_ovr;
    logic [RW-1:0]          buf_wdata, rev_data;

    logic [9:0]             dy;
    logic                   visible, last;
    logic [3:0]             row;
    logic                   unused_cfg;

    assign unused_cfg = cfg_data[31];

    // Line/sprite Y delta in 10-bit signed; 0..15 means the line hits the sprite.
    assign dy      = {line_y[8], line_y} - {cfg_data[8], cfg_data[8:0]};
    assign visible = cfg_data[28] && (dy[9:4] == 6'd0);
    assign row     = cfg_data[29] ? ~dy[3:0] : dy[3:0];
    assign last    = (s_q == 4'(NUM_SPRITES - 1));

    assign cfg_idx    = s_q;
    assign mem_req    = (state_q == REQ);
    assign mem_addr   = mem_addr_q;
    assign fetch_done = (state_q == DONE);

    always_comb begin
        rev_data = '0;
        for (int g = 0; g < SPRITE_W; g++)
            rev_data[g*BPP +: BPP] = mem_data[(SPRITE_W-1-g)*BPP +: BPP];
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        buf_we     = 1'b0;
        buf_wdata  = '0;
        cfg_we     = 1'b0;
        set_loaded = 1'b0;
        clr_loaded = 1'b0;
        line_ovr   = 1'b0;
        if (line_start) begin
            state_d    = CFG;
            s_d        = 4'd0;
            clr_loaded = 1'b1;
            line_ovr   = (state_q == CFG) || (state_q == REQ);
        end else begin
            unique case (state_q)
                CFG: begin
                    if (visible) begin
                        cfg_we  = 1'b1;
                        state_d = REQ;
                    end else begin
                        buf_we     = 1'b1;
                        set_loaded = 1'b1;
                        state_d    = last ? DONE : CFG;
                        s_d        = last ? s_q : s_q + 4'd1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        buf_we     = 1'b1;
                        buf_wdata  = xflip_q ? rev_data : mem_data;
                        set_loaded = 1'b1;
                        state_d    = last ? DONE : CFG;
                        s_d        = last ? s_q : s_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            s_q        <= 4'd0;
            loaded_q   <= '0;
            xflip_q    <= 1'b0;
            mem_addr_q <= 9'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            if (cfg_we) begin
                xflip_q    <= cfg_data[30];
                mem_addr_q <= {cfg_data[23:19], row};
            end
            if (clr_loaded)
                loaded_q <= '0;
            else
                for (int i = 0; i < NUM_SPRITES; i++)
                    if (set_loaded && s_q == 4'(i))
                        loaded_q[i] <= 1'b1;
        end
    end

    // Row data and per-sprite attributes carry no reset value; loaded_q
    // gates their use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (buf_we && s_q == 4'(i))
                row_buf[i] <= buf_wdata;
            if (cfg_we && s_q == 4'(i)) begin
                spr_x[i]   <= cfg_data[18:9];
                spr_pal[i] <= cfg_data[27:24];
            end
        end
    end

    logic [10:0]            col [NUM_SPRITES];
    logic [BPP-1:0]         pv  [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] opaque, coll_new;
    logic [BPP-1:0]         win_pix;
    logic [3:0]             win_pal;
    logic                   found;

    always_comb begin
        opaque  = '0;
        win_pix = '0;
        win_pal = 4'd0;
        found   = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            col[i] = {pix_x[9], pix_x} - {spr_x[i][9], spr_x[i]};
            pv[i]  = '0;
            // Only in-range columns match, so negative X clips for free.
            for (int c = 0; c < SPRITE_W; c++)
                if (col[i] == 11'(c))
                    pv[i] = row_buf[i][(SPRITE_W-1-c)*BPP +: BPP];
            opaque[i] = loaded_q[i] && (pv[i] != '0);
            if (opaque[i] && !found) begin
                found   = 1'b1;
                win_pix = pv[i];
                win_pal = spr_pal[i];
            end
        end
        coll_new = (pix_valid && $countones(opaque) > 1) ? opaque : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_valid       <= 1'b0;
            px_pixel       <= '0;
            px_palette     <= 4'd0;
            collision_mask <= '0;
            fetch_overrun  <= 1'b0;
        end else begin
            px_valid <= pix_valid;
            if (pix_valid) begin
                px_pixel   <= win_pix;
                px_palette <= win_pal;
            end
            // New events are OR-ed after the clear, so a same-cycle set wins.
            collision_mask <= (clr_collision ? '0 : collision_mask) | coll_new;
            fetch_overrun  <= (clr_collision ? 1'b0 : fetch_overrun)
                            | line_ovr
                            | (pix_valid && state_q != DONE);
        end
    end

endmodule

// File: doc/sprite_line_engine.md
# sprite_line_engine

Parametrised scanline sprite engine for the tile/sprite video peripheral. During horizontal blank it walks every sprite control word and fetches one row of pixel data per Y-visible sprite from sprite memory through a variable-latency request/acknowledge port. During the active line it outputs the highest-priority opaque sprite pixel and palette for each pixel position. Compared with the fixed eight-sprite rasteriser, it adds:
- configurable sprite count, width and depth;
- correct clipping at negative X;
- a sticky sprite-collision mask;
- detection of fetch overrun.

## Interface
- NUM_SPRITES, 8: sprites walked per line, 1..16; lower index has higher priority.
- SPRITE_W, 16: pixels per sprite row, 8 or 16; sprite height is fixed at 16 rows.
- BPP, 2: bits per pixel, 1, 2 or 4; pixel value 0 is transparent. RW = SPRITE_W*BPP, at most 64.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous and active-high.
- line_start  in  1  single-cycle pulse at hblank start; begins the fetch for line_y.
- line_y  in  9  signed screen line to be displayed next.
- cfg_idx  out  4  sprite index whose control word is being read.
- cfg_data  in  32  control word for cfg_idx, returned combinationally. Fields:
  - [8:0] y, signed
  - [18:9] x, signed
  - [23:19] image index
  - [27:24] palette
  - [28] enable
  - [29] Y-flip
  - [30] X-flip
- mem_req  out  1  row fetch request; held high until acknowledged.
- mem_addr  out  9  {image index, row[3:0]}.
- mem_ack  in  1  mem_data valid; sampled only while mem_req=1.
- mem_data  in  RW  sprite row; leftmost pixel in the MSBs.
- pix_valid  in  1  one active-video pixel this cycle.
- pix_x  in  10  signed X of that pixel.
- px_valid  out  1  px_* outputs are valid.
- px_pixel  out  BPP  winning pixel value; 0 means no sprite.
- px_palette  out  4  palette of the winning sprite.
- collision_mask  out  NUM_SPRITES  sticky; bit i set when sprite i overlapped another opaque sprite.
- clr_collision  in  1  clears collision_mask.
- fetch_done  out  1  high when all sprites for the current line have been processed.
- fetch_overrun  out  1  sticky; cleared by clr_collision.

## Operation
- FSM states: IDLE, CFG, REQ, DONE.
- line_start, from any state:
  - sprite counter s = 0;
  - every loaded[i] cleared;
  - enter CFG;
  - fetch_done = 0.
- If line_start arrives while in CFG or REQ, set fetch_overrun; any outstanding request is dropped.
- CFG, with cfg_idx = s:
  - d = line_y − cfg_data.y, computed at 10 bits signed;
  - the sprite is visible if enable=1 and 0 ≤ d ≤ 15;
  - row = Y-flip ? 15−d[3:0] : d[3:0].
- Visible sprite in CFG:
  - register mem_addr = {index, row}, x, palette and X-flip;
  - enter REQ.
- Invisible sprite in CFG:
  - row buffer[s] = 0 and loaded[s] = 1;
  - s+1, or DONE after the last sprite.
- REQ:
  - mem_req = 1;
  - on mem_ack, store mem_data into buffer[s], reversed in BPP-bit groups if X-flip is set;
  - set loaded[s] = 1;
  - mem_req falls in the next cycle, and the FSM moves to CFG for s+1 or to DONE.
- DONE: fetch_done = 1. The FSM stays in DONE until the next line_start.
- Pixel stage, on pix_valid:
  - per sprite, col = pix_x − x, computed at 11 bits signed;
  - the sprite is opaque if loaded[i] and 0 ≤ col < SPRITE_W and the pixel in buffer[i] at col is non-zero;
  - the lowest-index opaque sprite supplies px_pixel and px_palette;
  - if no sprite is opaque, px_pixel = 0 and px_palette = 0.
- Negative x clips naturally, because columns with col < 0 are never displayed.
- Overrun: if pix_valid occurs while fetch_done = 0, set fetch_overrun. Sprites not yet loaded are treated as transparent for that pixel.
- Collision: if two or more sprites are opaque in the same pixel, OR all of their bits into collision_mask.
- clr_collision and a new collision in the same cycle: the mask ends up holding exactly the new bits, so set wins.
- clr_collision and a new overrun in the same cycle: fetch_overrun = 1.

## Timing
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - loaded[] = 0;
  - buffers are don't-care.
- line_start in cycle t: cfg_idx = 0 in cycle t+1.
- Invisible sprite: 1 cycle.
- Visible sprite: CFG in cycle c; mem_req is high from c+1 through the cycle in which mem_ack is sampled (minimum 1 cycle).
- Fetch time: NUM_SPRITES + Σ(ack latency) cycles.
- fetch_done rises in the cycle after the last sprite is processed.
- Pixel latency: px_valid, px_pixel, px_palette and collision_mask updates are registered and appear exactly 1 cycle after pix_valid.
- If pix_valid is low, px_valid = 0 and px_pixel/px_palette hold their previous values.
- Reset mid-fetch:
  - mem_req drops immediately (asynchronous reset);
  - the FSM returns to IDLE;
  - a late mem_ack is ignored.

## Test plan
- **Single sprite, defaults:**
  - sprite0 at y=10, x=20, enable=1, palette 3, row 2 = 0x4000_0001; line_y=12, ack latency 1;
  - expect mem_addr = {idx,2}, fetch_done after 9 cycles;
  - pix_x=20 gives px_pixel=1, palette 3; pix_x=35 gives 1; pix_x=19 and 36 give 0.
- **Y-flip / X-flip:**
  - same sprite with Y-flip gives mem_addr row 13;
  - X-flip on row 0xC000_0000 makes pix_x=35 give 3.
- **Negative X:** x=−4 (0x3FC); pix_x=0 reads column 4 and pix_x=11 reads column 15; no pixel is output at pix_x=12.
- **Priority and collision:**
  - sprites 1 and 5 opaque at pix_x=50: px_palette comes from sprite 1 and collision_mask=0x22;
  - clr_collision in the same cycle as the collision leaves the mask at 0x22;
  - a lone clr_collision clears it to 0.
- **Overrun:**
  - ack latency 20 with 8 visible sprites; pix_valid at cycle 40 after line_start;
  - expect fetch_overrun=1 and unloaded sprites transparent;
  - a line_start mid-REQ restarts at cfg_idx=0.
- **Parameter sweep:**
  - NUM_SPRITES=16, SPRITE_W=8, BPP=4: row 0xF000_0000 gives px_pixel=0xF at col 0;
  - async reset mid-REQ drops mem_req in the same cycle.
